// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam logic [ID_W-1:0] PTR_RST = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/pri_encoder_83.sv
// rtl/pri_encoder_83.sv - 8:3 priority encoder, bit 7 has highest priority
module pri_encoder_83 (
  input  logic [7:0] d,
  output logic [2:0] y,
  output logic       valid
);
  always_comb begin
    y     = '0;
    valid = |d;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) y = 3'(i);
    end
  end
endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - picks the first requester after ptr, wrapping, using the 8:3 encoder
import rr_arb_pkg::*;

module rr_pick8 (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);
  logic [ID_W-1:0]  shift;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rev;
  logic [ID_W-1:0]  enc_y;

  assign shift = ptr + 3'd1;

  // rot[0] is the requester just after ptr; reversing puts it on the encoder's top bit
  always_comb begin
    rot = '0;
    rev = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[3'(i) + shift];
    end
    for (int i = 0; i < N_REQ; i++) begin
      rev[i] = rot[N_REQ-1-i];
    end
  end

  pri_encoder_83 u_enc (
    .d     (rev),
    .y     (enc_y),
    .valid (any)
  );

  assign winner = (3'd7 - enc_y) + shift;
endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter with grant hold, hold-time limit and turnaround gap
import rr_arb_pkg::*;

module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);
  localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HCNT_W'(MAX_HOLD - 1) : '0;

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [ID_W-1:0]   gnt_id_d;
  logic              gnt_valid_d;
  logic              preempt_d;
  logic [ID_W-1:0]   winner;
  logic              any;
  logic              hold_expired;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RST;
      hcnt_q    <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      preempt   <= preempt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    preempt_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d     = ST_GRANT;
          gnt_d       = N_REQ'(1) << winner;
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          hcnt_d      = '0;
        end
      end
      ST_GRANT: begin
        // Any release goes back through IDLE, which gives the one-cycle turnaround gap
        if (!req[gnt_id] || hold_expired) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id;
          preempt_d   = req[gnt_id];
        end else if (MAX_HOLD != 0) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule
